if_id_fetch_queue: RTL and testbench
====================================

// Module: if_id_fetch_queue
// PURPOSE
//  Decoupling FIFO between the IF stage and the ID stage.
//  - Buffers fetched {instruction, PC+4} pairs so that an ID stall does not have to stop fetch immediately.
//  - Drives back-pressure to IF: IF freeze = ~in_ready.
//  - Discards all wrong-path entries when a branch is taken.
//  - Replaces the plain IF/ID register. The head entry feeds ID combinationally.
// PARAMETERS
//  DEPTH   4   entries; power of two, >= 2
//  DATA_W  32  instruction width and PC width
// PORTS
//  clk              in   1                   clock; all state changes on the rising edge
//  rst              in   1                   asynchronous, active-low reset
//  flush            in   1                   branch taken; empty the queue at the next edge
//  in_valid         in   1                   IF presents a fetched instruction this cycle
//  in_instruction   in   DATA_W              fetched instruction
//  in_pc            in   DATA_W              PC+4 (adder output) of that instruction
//  in_ready         out  1                   queue can accept; equals ~full
//  out_valid        out  1                   head entry valid; equals ~empty
//  out_instruction  out  DATA_W              head instruction; 0 (NOP bubble) when empty
//  out_pc           out  DATA_W              head PC+4; 0 when empty
//  out_ready        in   1                   ID consumes the head this cycle (~hazard stall)
//  count            out  $clog2(DEPTH)+1     number of valid entries
// BEHAVIOUR
//  Reset (rst=0, asynchronous): wr_ptr=rd_ptr=0, count=0, out_valid=0, out_*=0, in_ready=1.
//    Storage contents are don't-care.
//  push = in_valid & in_ready & ~flush
//  pop  = out_valid & out_ready & ~flush
//  Edge behaviour:
//    - push writes mem[wr_ptr] and increments wr_ptr (mod DEPTH).
//    - pop increments rd_ptr (mod DEPTH).
//    - count: +1 on push only, -1 on pop only, unchanged when both or neither.
//  Ready/valid:
//    - in_ready depends only on count (count != DEPTH). It is not a function of out_ready:
//      a full queue refuses a push even in a cycle where it pops.
//    - out_valid = (count != 0).
//    - out_instruction/out_pc = mem[rd_ptr] when out_valid, else 0.
//    - All outputs are purely combinational from registers; no in->out combinational path.
//  Latency: an entry pushed at edge N is visible on out_* right after edge N (one cycle).
//    - Pushing into an empty queue never bypasses combinationally.
//  Ordering: strict FIFO. Pointers wrap modulo DEPTH with no gap.
//  Flush (flush=1 at an edge): wr_ptr=rd_ptr=0, count=0.
//    - The same-cycle push and pop are both suppressed.
//    - The next cycle shows out_valid=0 and in_ready=1.
//  Pop while empty and push while full are illegal handshakes. They are masked internally:
//    no pointer or count change.
//  count never exceeds DEPTH and never underflows.
//  Reset asserted mid-operation returns everything to the reset state immediately (async),
//    with no dependence on clk.
// TESTING
//  1. Reset (rst=0), then release -> count=0, out_valid=0, out_instruction=0, in_ready=1.
//  2. out_ready=0; push I0..I3 = 32'hE0000001..4 with in_pc 4,8,12,16 ->
//     count=4, in_ready=0; a 5th push is dropped; head stays E0000001/4.
//  3. From full: out_ready=1, in_valid=0 for 4 cycles -> heads E0000001..4 in order,
//     then out_valid=0, out_instruction=0.
//  4. count=2: push and pop in the same cycle for 6 cycles ->
//     count stays 2; order preserved across pointer wrap.
//  5. count=3 with in_valid=1 and flush=1 in one cycle ->
//     next cycle count=0, out_valid=0; the flushed-cycle instruction never appears.
//  6. count=3; drop rst between edges -> outputs reach reset values before the next clk edge;
//     after release, push then pop returns the new data.

Source files
------------

// File: rtl/if_id_fetch_queue.sv
// IF/ID decoupling FIFO: buffers {instruction, PC+4} pairs,
// back-pressures fetch and drops wrong-path entries on flush.
module if_id_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_instruction,
  input  logic [DATA_W-1:0]        in_pc,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_instruction,
  output logic [DATA_W-1:0]        out_pc,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_instr [DEPTH];
  logic [DATA_W-1:0] mem_pc    [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic              push;
  logic              pop;

  assign in_ready  = (cnt != CW'(DEPTH));
  assign out_valid = (cnt != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign count     = cnt;

  // Head entry is shown only when valid; otherwise a NOP bubble
  assign out_instruction = out_valid ? mem_instr[rd_ptr] : '0;
  assign out_pc          = out_valid ? mem_pc[rd_ptr]    : '0;

  // Storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= in_instruction;
      mem_pc[wr_ptr]    <= in_pc;
    end
  end

  // Pointers and occupancy; flush empties the queue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case (1'b1)
        (push & ~pop): cnt <= cnt + CW'(1);
        (pop & ~push): cnt <= cnt - CW'(1);
        default:       cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Self-checking bench for if_id_fetch_queue against
// a queue-based reference model with random traffic.
module tb_if_id_fetch_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instruction;
  logic [31:0] in_pc;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic        out_ready;
  logic [2:0]  count;

  int errs;
  int checks;
  logic [63:0] q[$];

  if_id_fetch_queue #(.DEPTH(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid),
    .in_instruction(in_instruction),
    .in_pc(in_pc), .in_ready(in_ready),
    .out_valid(out_valid),
    .out_instruction(out_instruction),
    .out_pc(out_pc), .out_ready(out_ready),
    .count(count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    logic [63:0] h;
    h = (q.size() > 0) ? q[0] : 64'd0;
    chk("count", 64'(count), 64'(q.size()));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() != 4));
    chk("out_instr", 64'(out_instruction), 64'(h[63:32]));
    chk("out_pc", 64'(out_pc), 64'(h[31:0]));
  endtask

  task automatic step(input logic f, input logic iv,
                      input logic [31:0] ii,
                      input logic [31:0] ip,
                      input logic orr);
    bit ps, pp;
    flush = f;
    in_valid = iv;
    in_instruction = ii;
    in_pc = ip;
    out_ready = orr;
    ps = iv && (q.size() < 4) && !f;
    pp = orr && (q.size() > 0) && !f;
    @(posedge clk);
    #1;
    if (f) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (ps) q.push_back({ii, ip});
    end
    chk_model();
  endtask

  task automatic idle();
    flush = 0;
    in_valid = 0;
    in_instruction = 0;
    in_pc = 0;
    out_ready = 0;
  endtask

  initial begin
    errs = 0;
    checks = 0;
    idle();
    rst = 0;
    #12;
    chk("rst_cnt", 64'(count), 64'd0);
    chk("rst_vld", 64'(out_valid), 64'd0);
    chk("rst_ins", 64'(out_instruction), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    chk_model();

    // fill, then a dropped fifth push
    for (int k = 0; k < 5; k++)
      step(0, 1, 32'hE0000001 + k, 32'(4 * (k + 1)), 0);
    chk("full_cnt", 64'(count), 64'd4);
    chk("full_head", 64'(out_instruction), 64'hE0000001);
    chk("full_pc", 64'(out_pc), 64'd4);

    // drain in order
    for (int k = 0; k < 4; k++) begin
      chk("drain_ord", 64'(out_instruction),
          64'(32'hE0000001 + k));
      step(0, 0, 0, 0, 1);
    end
    chk("drain_vld", 64'(out_valid), 64'd0);

    // pop while empty is masked
    step(0, 0, 0, 0, 1);

    // steady push+pop at count 2 across wrap
    step(0, 1, 32'hA0000000, 32'h100, 0);
    step(0, 1, 32'hA0000001, 32'h104, 0);
    for (int k = 2; k < 8; k++)
      step(0, 1, 32'hA0000000 + k, 32'h100 + 4 * k, 1);
    chk("wrap_cnt", 64'(count), 64'd2);
    chk("wrap_head", 64'(out_instruction), 64'hA0000006);

    // full queue refuses push even while popping
    step(0, 1, 32'hA0000008, 32'h120, 0);
    step(0, 1, 32'hA0000009, 32'h124, 0);
    step(0, 1, 32'hBAD00000, 32'h0, 1);
    chk("fullpop_cnt", 64'(count), 64'd3);

    // flush with a same-cycle push
    step(1, 1, 32'hDEADBEEF, 32'h999, 1);
    chk("fl_cnt", 64'(count), 64'd0);
    chk("fl_rdy", 64'(in_ready), 64'd1);
    step(0, 1, 32'hC0000001, 32'h200, 0);
    chk("fl_next", 64'(out_instruction), 64'hC0000001);

    // async reset mid-cycle at count 3
    step(0, 1, 32'hC0000002, 32'h204, 0);
    step(0, 1, 32'hC0000003, 32'h208, 0);
    #3 rst = 0;
    #1;
    q.delete();
    chk("arst_cnt", 64'(count), 64'd0);
    chk("arst_vld", 64'(out_valid), 64'd0);
    chk("arst_ins", 64'(out_instruction), 64'd0);
    chk("arst_rdy", 64'(in_ready), 64'd1);
    #1 rst = 1;
    step(0, 1, 32'hF0000001, 32'h300, 0);
    chk("arst_new", 64'(out_instruction), 64'hF0000001);
    step(0, 0, 0, 0, 1);

    // random traffic
    for (int n = 0; n < 400; n++)
      step(($urandom_range(0, 19) == 0),
           $urandom_range(0, 3) != 0,
           $urandom, $urandom,
           $urandom_range(0, 2) != 0);

    idle();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
